seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001: Parameter MAX_LEN, default 8: maximum pattern length in bits, range 2..32.
REQ-002: Parameter CNT_W, default 16: width of the match counter.
REQ-003: Parameter DEF_PATTERN, default 8'b0000_1010: reset pattern, right-aligned.
REQ-004: Parameter DEF_LEN, default 4: reset pattern length.
REQ-005: Parameter DEF_OVERLAP, default 1: reset mode, 1 = overlapping, 0 = non-overlapping.
REQ-006: Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007: Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008: Port din_valid, input, 1 bit: din is sampled only on edges where din_valid = 1.
REQ-009: Port din, input, 1 bit: serial data bit.
REQ-010: Port cfg_we, input, 1 bit: load cfg_pattern, cfg_len and cfg_overlap.
REQ-011: Port cfg_pattern, input, MAX_LEN bits: bit [cfg_len-1] is the first bit expected; bit [0] is the last.
REQ-012: Port cfg_len, input, $clog2(MAX_LEN+1) bits: pattern length.
REQ-013: Port cfg_overlap, input, 1 bit: detection mode.
REQ-014: Port cnt_clr, input, 1 bit: synchronous clear of match_cnt.
REQ-015: Port dout, output, 1 bit: one-cycle match pulse, registered.
REQ-016: Port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-017: Port cfg_err, output, 1 bit: registered; high while the active length is invalid.

Function
REQ-018: Shift a sampled bit into a history register, newest bit at position 0, on every edge with din_valid = 1.
REQ-019: Track fill = number of valid history bits, saturating at MAX_LEN.
REQ-020: Declare a match when, after the shift, fill >= len and history[len-1:0] == pattern[len-1:0].
REQ-021: On a match edge, set dout = 1 for exactly one cycle; latency is one edge from the final pattern bit; otherwise dout = 0.
REQ-022: In overlap mode, leave fill unchanged on a match, so trailing bits may begin the next match.
REQ-023: In non-overlap mode, set fill to 0 on a match, so no bit of a matched sequence is reused.
REQ-024: On an edge with din_valid = 0, change neither history nor fill, and hold dout at 0.
REQ-025: On cfg_we, latch the three cfg fields, clear history and fill to 0, and force dout to 0; a din sampled in the same cycle is discarded.
REQ-026: Treat a latched length of 0, 1 or > MAX_LEN as invalid: set cfg_err = 1, suppress all matches, and keep shifting history.
REQ-027: Increment match_cnt by 1 on each match and hold it at 2^CNT_W-1 with no wrap.
REQ-028: When cnt_clr and a match occur on the same edge, set match_cnt to 1; when cnt_clr occurs alone, set it to 0.
REQ-029: Never let cnt_clr affect history, fill or configuration.

Reset
REQ-030: While rst = 1, hold: history = 0, fill = 0, dout = 0, match_cnt = 0, cfg_err = 0, pattern = DEF_PATTERN, len = DEF_LEN, overlap = DEF_OVERLAP.
REQ-031: Assert reset immediately, independent of clk; reset mid-sequence discards the partial match, and no dout pulse is produced for it.
REQ-032: After rst deasserts, the first sampled bit is treated as pattern position len-1.

Structure
REQ-033: Place in shared package seq_pkg: the length-width constant function, the default pattern and length constants, and the mode encoding (OVERLAP = 1, NON_OVERLAP = 0).
REQ-034: Implement the saturating counter with clear as sub-module sat_counter (parameter W; ports clk, rst, inc, clr, q), reusable elsewhere.
REQ-035: Keep the rest (history shift, fill, compare, config registers) in seq_detect_param; the design is fully synthesizable with no latches.

Verification
REQ-036: Defaults, continuous valid, din = 1,0,1,0,1,0 -> dout pulses after bit 4 and bit 6; match_cnt = 2.
REQ-037: cfg pattern 1010, len 4, overlap 0, din = 1,0,1,0,1,0 -> single dout pulse after bit 4; match_cnt = 1.
REQ-038: cfg pattern 8'b1100_1011, len 8, din_valid toggling 1,0 with that bit stream -> exactly one pulse after the 8th valid bit; no pulse on invalid cycles.
REQ-039: cfg_len = 0 then stream 1010 -> cfg_err = 1, no pulses; reconfigure with len 4 -> cfg_err = 0, detection resumes.
REQ-040: CNT_W = 2, five matches -> match_cnt goes 1,2,3,3,3; cnt_clr coincident with the 6th match -> match_cnt = 1.
REQ-041: rst asserted mid-clock after bits 1,0,1, then released and 0 sent -> no pulse; all outputs 0 while rst = 1.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared constants, mode encoding and width helper for the sequence detector.
package seq_pkg;
  typedef enum logic {NON_OVERLAP = 1'b0, OVERLAP = 1'b1} mode_e;
  localparam logic [7:0] DEF_PATTERN_C = 8'b0000_1010;
  localparam int DEF_LEN_C = 4;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear; a coincident increment wins over clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clr ? (inc ? W'(1) : '0) : (inc && ~&q_q) ? q_q + W'(1) : q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-configurable serial pattern detector with overlap mode and match counter.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int                 DEF_LEN     = DEF_LEN_C,
  parameter bit                 DEF_OVERLAP = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        din_valid,
  input  logic                        din,
  input  logic                        cfg_we,
  input  logic [MAX_LEN-1:0]          cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
  input  logic                        cfg_overlap,
  input  logic                        cnt_clr,
  output logic                        dout,
  output logic [CNT_W-1:0]            match_cnt,
  output logic                        cfg_err
);
  localparam int LW = len_w(MAX_LEN);
  logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d, hist_sh, mask;
  logic [LW-1:0]      fill_q, fill_d, len_q, len_d, fill_inc;
  mode_e              ovl_q, ovl_d;
  logic               err_q, err_d, dout_q, hit;
  always_comb begin
    hist_sh  = {hist_q[MAX_LEN-2:0], din};
    fill_inc = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
    mask     = ~({MAX_LEN{1'b1}} << len_q);
    hit      = din_valid && !cfg_we && !err_q && (fill_inc >= len_q) && (((hist_sh ^ pat_q) & mask) == '0);
    hist_d   = cfg_we ? '0 : din_valid ? hist_sh : hist_q;
    fill_d   = cfg_we ? '0 : !din_valid ? fill_q : (hit && ovl_q == NON_OVERLAP) ? '0 : fill_inc;
    pat_d    = cfg_we ? cfg_pattern : pat_q;
    len_d    = cfg_we ? cfg_len : len_q;
    ovl_d    = cfg_we ? mode_e'(cfg_overlap) : ovl_q;
    err_d    = cfg_we ? (cfg_len < LW'(2) || cfg_len > LW'(MAX_LEN)) : err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LW'(DEF_LEN);
      ovl_q  <= mode_e'(DEF_OVERLAP);
      err_q  <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      err_q  <= err_d;
      dout_q <= hit;
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(cnt_clr),
    .q  (match_cnt)
  );
  assign dout    = dout_q;
  assign cfg_err = err_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench driving a default instance and a 2-bit-counter instance in parallel.
module tb_seq_detect_param;
  typedef struct {
    logic        dout;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        err;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        din_valid = 1'b0, din = 1'b0, cfg_we = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        dout, cfg_err, dout2, cfg_err2;
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt2;
  exp_t        exp_q[$];
  int          n_chk = 0, n_err = 0;
  int          e_cnt = 0, e_cnt2 = 0;
  logic        e_err = 1'b0;
  logic [7:0]  pat8 = 8'b1100_1011;

  seq_detect_param u_dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .dout(dout), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );
  seq_detect_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .dout(dout2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic e, input logic clr);
    if (clr) begin
      e_cnt  = e ? 1 : 0;
      e_cnt2 = e ? 1 : 0;
    end else if (e) begin
      e_cnt  = e_cnt + 1;
      e_cnt2 = (e_cnt2 == 3) ? 3 : e_cnt2 + 1;
    end
    exp_q.push_back('{dout: e, cnt: 16'(e_cnt), cnt2: 2'(e_cnt2), err: e_err});
  endtask

  task automatic step(input logic v, input logic d, input logic e, input logic clr = 1'b0);
    @(negedge clk);
    cfg_we = 1'b0; din_valid = v; din = d; cnt_clr = clr;
    push(e, clr);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    din_valid = 1'b1; din = 1'b1; cnt_clr = 1'b0;
    e_err = (l < 4'd2) || (l > 4'd8);
    push(1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("dout",    32'(dout),       32'(x.dout));
      chk("cnt",     32'(match_cnt),  32'(x.cnt));
      chk("err",     32'(cfg_err),    32'(x.err));
      chk("dout2",   32'(dout2),      32'(x.dout));
      chk("cnt2",    32'(match_cnt2), 32'(x.cnt2));
      chk("err2",    32'(cfg_err2),   32'(x.err));
    end
  end

  initial begin
    #12;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_cnt",  32'(match_cnt), 0);
    chk("rst_err",  32'(cfg_err), 0);
    @(negedge clk); rst = 1'b0;
    // defaults, overlapping 1010
    step(1,1,0); step(1,0,0); step(1,1,0); step(1,0,1); step(1,1,0); step(1,0,1);
    step(0,0,0,1);
    // non-overlapping
    cfg(8'b1010, 4'd4, 1'b0);
    step(1,1,0); step(1,0,0); step(1,1,0); step(1,0,1); step(1,1,0); step(1,0,0);
    // full-length pattern with gapped valid
    cfg(pat8, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      step(1, pat8[i], i == 0);
      step(0, ~pat8[i], 0);
    end
    // invalid lengths then recovery
    cfg(8'b1010, 4'd0, 1'b1);
    step(1,1,0); step(1,0,0); step(1,1,0); step(1,0,0);
    cfg(8'b1010, 4'd9, 1'b1);
    step(1,1,0); step(1,0,0); step(1,1,0); step(1,0,0);
    cfg(8'b1010, 4'd4, 1'b1);
    step(1,1,0); step(1,0,0); step(1,1,0); step(1,0,1);
    // minimum length and counter saturation
    cfg(8'b01, 4'd2, 1'b1);
    step(0,0,0,1);
    for (int i = 0; i < 5; i++) begin
      step(1,0,0); step(1,1,1);
    end
    step(1,0,0); step(1,1,1,1);
    step(0,0,0,1);
    // async reset mid-sequence
    cfg(8'b1010, 4'd4, 1'b0);
    step(1,1,0); step(1,0,0); step(1,1,0); step(1,0,1);
    step(1,1,0); step(1,0,0); step(1,1,0);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("arst_dout", 32'(dout), 0);
    chk("arst_cnt",  32'(match_cnt), 0);
    chk("arst_cnt2", 32'(match_cnt2), 0);
    chk("arst_err",  32'(cfg_err), 0);
    din_valid = 1'b1; din = 1'b0;
    @(posedge clk); #2;
    chk("rst_hold_dout", 32'(dout), 0);
    chk("rst_hold_cnt",  32'(match_cnt), 0);
    @(negedge clk); rst = 1'b0;
    e_cnt = 0; e_cnt2 = 0; e_err = 1'b0;
    exp_q.delete();
    step(1,0,0);
    step(1,1,0); step(1,0,0); step(1,1,0); step(1,0,1); step(1,1,0); step(1,0,1);
    step(0,0,0); step(0,0,0);
    @(posedge clk); #2;
    chk("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
